// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light loop-detector conditioner:
// channel state encoding and default timing/width constants.
package tl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_QUAL   = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_HOLD   = 2'b11
    } chan_state_e;

    localparam int DEB_CYCLES_DEF  = 4;
    localparam int HOLD_CYCLES_DEF = 8;
    localparam int CNT_W_DEF       = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tl_sensor_chan.sv
// One conditioning channel: optional 2-flop synchronizer (TL_SENSOR_SYNC_EN),
// debounce/hold FSM with run counter, and saturating arrival counter.
module tl_sensor_chan
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_raw,
    input  logic             i_clr_cnt,
    output logic             o_t,
    output logic [CNT_W-1:0] o_car_cnt
);

    localparam int RUN_W = $clog2(max_int(DEB_CYCLES, HOLD_CYCLES)) + 1;
    localparam logic [RUN_W-1:0] DEB_LAST  = RUN_W'(DEB_CYCLES - 1);
    localparam logic [RUN_W-1:0] HOLD_LAST = RUN_W'(HOLD_CYCLES - 1);

    chan_state_e      r_state;
    chan_state_e      w_state_nxt;
    logic [RUN_W-1:0] r_cnt;
    logic [RUN_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_car_cnt;
    logic             w_arrive;
    logic             w_s;

`ifdef TL_SENSOR_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer for the asynchronous loop input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = i_raw;
`endif

    // Next-state, run counter and arrival-event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_arrive    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = ST_QUAL;
                    w_cnt_nxt   = RUN_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_QUAL: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = '0;
                    w_arrive    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + RUN_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (!w_s) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = RUN_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_HOLD: begin
                // A returning vehicle inside the hold window is the same occupancy.
                if (w_s) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + RUN_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, run counter and saturating arrival counter; clear beats increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_car_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (i_clr_cnt) begin
                r_car_cnt <= '0;
            end else if (w_arrive && (r_car_cnt != {CNT_W{1'b1}})) begin
                r_car_cnt <= r_car_cnt + CNT_W'(1);
            end else begin
                r_car_cnt <= r_car_cnt;
            end
        end
    end

    assign o_t       = (r_state == ST_ACTIVE) || (r_state == ST_HOLD);
    assign o_car_cnt = r_car_cnt;

endmodule

// File: rtl/tl_sensor_cond.sv
// Two independent loop-detector conditioning channels (street A and B).
// Optional input synchronizers enabled by defining TL_SENSOR_SYNC_EN.
module tl_sensor_cond
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_a,
    input  logic             raw_b,
    input  logic             clr_cnt,
    output logic             Ta,
    output logic             Tb,
    output logic [CNT_W-1:0] car_cnt_a,
    output logic [CNT_W-1:0] car_cnt_b
);

    tl_sensor_chan #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_chan_a (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (raw_a),
        .i_clr_cnt(clr_cnt),
        .o_t      (Ta),
        .o_car_cnt(car_cnt_a)
    );

    tl_sensor_chan #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_chan_b (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (raw_b),
        .i_clr_cnt(clr_cnt),
        .o_t      (Tb),
        .o_car_cnt(car_cnt_b)
    );

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Bench for tl_sensor_cond: run-length occupancy model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tl_sensor_cond;

    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int CMAX  = 255;
`ifdef TL_SENSOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       raw_a = 1'b0;
    logic       raw_b = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       Ta;
    logic       Tb;
    logic [7:0] car_cnt_a;
    logic [7:0] car_cnt_b;

    int total = 0;
    int bad   = 0;

    tl_sensor_cond dut (
        .clk      (clk),
        .reset    (reset),
        .raw_a    (raw_a),
        .raw_b    (raw_b),
        .clr_cnt  (clr_cnt),
        .Ta       (Ta),
        .Tb       (Tb),
        .car_cnt_a(car_cnt_a),
        .car_cnt_b(car_cnt_b)
    );

    always #5 clk = ~clk;

    // Model: a flag turns on after DEB consecutive highs, off after HOLD consecutive lows.
    bit m_flag[2];
    int m_hi[2];
    int m_lo[2];
    int m_cnt[2];
    bit m_d1[2];
    bit m_d2[2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_flag[c] = 1'b0; m_hi[c] = 0; m_lo[c] = 0; m_cnt[c] = 0;
                m_d1[c] = 1'b0; m_d2[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                bit raw;
                bit s;
                bit arrive;
                raw = (c == 0) ? raw_a : raw_b;
                s = (LAT != 0) ? m_d2[c] : raw;
                m_d2[c] = m_d1[c];
                m_d1[c] = raw;
                arrive = 1'b0;
                if (!m_flag[c]) begin
                    if (s) begin
                        m_hi[c]++;
                        if (m_hi[c] == DEB) begin
                            m_flag[c] = 1'b1; m_hi[c] = 0; m_lo[c] = 0; arrive = 1'b1;
                        end
                    end else begin
                        m_hi[c] = 0;
                    end
                end else begin
                    if (!s) begin
                        m_lo[c]++;
                        if (m_lo[c] == HOLD) begin
                            m_flag[c] = 1'b0; m_lo[c] = 0; m_hi[c] = 0;
                        end
                    end else begin
                        m_lo[c] = 0;
                    end
                end
                if (clr_cnt) m_cnt[c] = 0;
                else if (arrive && m_cnt[c] < CMAX) m_cnt[c]++;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        chk("model_Ta", int'(Ta), int'(m_flag[0]));
        chk("model_Tb", int'(Tb), int'(m_flag[1]));
        chk("model_cnt_a", int'(car_cnt_a), m_cnt[0]);
        chk("model_cnt_b", int'(car_cnt_b), m_cnt[1]);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // 1: reset
        tick(2);
        chk("rst_Ta", int'(Ta), 0);
        chk("rst_Tb", int'(Tb), 0);
        chk("rst_cnt_a", int'(car_cnt_a), 0);
        reset = 1'b0;
        tick(3);
        chk("idle_cnt_b", int'(car_cnt_b), 0);

        // 2: short glitch
        raw_a = 1'b1;
        tick(3);
        chk("short_Ta", int'(Ta), 0);
        raw_a = 1'b0;
        tick(2 + LAT);
        chk("short_Ta_after", int'(Ta), 0);
        chk("short_cnt_a", int'(car_cnt_a), 0);

        // 3: long pulse, assert/deassert latency
        raw_a = 1'b1;
        tick(DEB + LAT - 1);
        chk("pre_assert_Ta", int'(Ta), 0);
        chk("pre_assert_cnt", int'(car_cnt_a), 0);
        tick(1);
        chk("assert_Ta", int'(Ta), 1);
        chk("assert_cnt_a", int'(car_cnt_a), 1);
        chk("assert_Tb", int'(Tb), 0);
        tick(20 - DEB - LAT);
        raw_a = 1'b0;
        tick(HOLD + LAT - 1);
        chk("pre_deassert_Ta", int'(Ta), 1);
        tick(1);
        chk("deassert_Ta", int'(Ta), 0);
        tick(2);

        // 4: gap shorter than hold on B
        raw_b = 1'b1;
        tick(DEB + LAT + 2);
        chk("b_on", int'(Tb), 1);
        raw_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("b_gap", int'(Tb), 1);
        end
        raw_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("b_gap_back", int'(Tb), 1);
        end
        chk("b_cnt", int'(car_cnt_b), 1);
        raw_b = 1'b0;
        tick(HOLD + LAT + 2);
        chk("b_off", int'(Tb), 0);

        // 5: saturation, then clear colliding with a qualification
        repeat (260) begin
            raw_a = 1'b1;
            tick(DEB + LAT);
            raw_a = 1'b0;
            tick(HOLD + LAT + 1);
        end
        chk("sat_cnt_a", int'(car_cnt_a), 255);
        chk("sat_cnt_b", int'(car_cnt_b), 1);
        raw_a = 1'b1;
        tick(DEB + LAT - 1);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        chk("clr_Ta", int'(Ta), 1);
        chk("clr_cnt_a", int'(car_cnt_a), 0);
        chk("clr_cnt_b", int'(car_cnt_b), 0);
        raw_a = 1'b0;
        tick(HOLD + LAT + 1);
        raw_a = 1'b1;
        tick(DEB + LAT);
        chk("post_clr_cnt_a", int'(car_cnt_a), 1);

        // 6: async reset while in HOLD
        raw_a = 1'b0;
        tick(2 + LAT);
        chk("hold_Ta", int'(Ta), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_Ta", int'(Ta), 0);
        chk("async_rst_cnt_a", int'(car_cnt_a), 0);
        #1;
        reset = 1'b0;
        tick(2);
        chk("after_rst_Ta", int'(Ta), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tl_sensor_cond.md
# tl_sensor_cond

Upstream conditioner for the traffic light controller. Takes raw, bouncy vehicle-loop detector inputs for street A and street B. Produces clean, debounced, minimum-hold occupancy flags `Ta`/`Tb`, which connect directly to the controller's `Ta`/`Tb` inputs. Also keeps a saturating per-street vehicle-arrival count for diagnostics.

## Interface
- `DEB_CYCLES`, 4: consecutive high samples required to assert a flag; legal range ≥2.
- `HOLD_CYCLES`, 8: consecutive low samples required to deassert a flag; legal range ≥2.
- `CNT_W`, 8: width of each arrival counter.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `raw_a`  in  1  raw loop detector, street A (asynchronous to `clk`).
- `raw_b`  in  1  raw loop detector, street B.
- `clr_cnt`  in  1  synchronous clear of both arrival counters.
- `Ta`  out  1  conditioned occupancy flag for street A.
- `Tb`  out  1  conditioned occupancy flag for street B.
- `car_cnt_a`  out  CNT_W  arrivals counted on street A.
- `car_cnt_b`  out  CNT_W  arrivals counted on street B.

## Operation
- Two identical, independent channels. Channel A uses `raw_a`, `Ta` and `car_cnt_a`; channel B uses `raw_b`, `Tb` and `car_cnt_b`.
- `s` is the sampled input: the raw pin, or the synchronizer output (see Configuration).
- Per-channel Moore FSM with a run counter `cnt`, sized `$clog2(max(DEB_CYCLES,HOLD_CYCLES))+1`:
  - IDLE (T=0): if s=1, go to QUAL and set cnt←1.
  - QUAL (T=0):
    - s=0: go to IDLE, cnt←0.
    - s=1 and cnt=DEB_CYCLES−1: go to ACTIVE and increment the arrival counter.
    - otherwise: cnt←cnt+1.
  - ACTIVE (T=1): if s=0, go to HOLD and set cnt←1.
  - HOLD (T=1):
    - s=1: go to ACTIVE, cnt←0. This is not a new arrival.
    - s=0 and cnt=HOLD_CYCLES−1: go to IDLE.
    - otherwise: cnt←cnt+1.
- `T` is decoded from the registered state only, so it is glitch-free.
- Arrival counter behaviour:
  - Increments only on the QUAL→ACTIVE transition.
  - Saturates at 2^CNT_W−1.
  - `clr_cnt` sets both counters to 0.
  - If `clr_cnt` and an increment occur in the same cycle, the clear wins and the counter is 0.
- Reset (asynchronous, active-high):
  - Both FSMs go to IDLE; cnt=0.
  - `Ta`=`Tb`=0.
  - Both counters are 0.
  - Synchronizer flops are 0.
  - Takes effect immediately, including mid-QUAL or mid-HOLD.

## Timing
- Assert latency: `T` rises after the DEB_CYCLES-th consecutive rising edge that samples s=1. With DEB_CYCLES=4 this is 4 cycles.
- Deassert latency: `T` falls after the HOLD_CYCLES-th consecutive rising edge that samples s=0.
- A high run shorter than DEB_CYCLES produces no pulse on `T` and no count.
- A low run shorter than HOLD_CYCLES during ACTIVE/HOLD leaves `T` continuously high.
- The arrival counter updates on the same edge that `T` rises.
- Channels never interact. Simultaneous events on A and B are both honoured in the same cycle.

## Configuration
- `TL_SENSOR_SYNC_EN` defined:
  - Each raw input passes through a 2-flop synchronizer before the FSM.
  - Both assert and deassert latencies grow by 2 cycles.
- `TL_SENSOR_SYNC_EN` undefined:
  - The FSM samples the raw input directly.
  - Intended for benches and for inputs already synchronous to `clk`.

## Structure
- Shared package `tl_pkg`:
  - Channel state encoding IDLE=2'b00, QUAL=2'b01, ACTIVE=2'b10, HOLD=2'b11.
  - Default constants for DEB_CYCLES, HOLD_CYCLES and CNT_W.
- One sub-module, `tl_sensor_chan`, holds one channel: optional synchronizer, FSM, run counter and saturating arrival counter.
- The top instantiates `tl_sensor_chan` twice.

## Test plan
Defaults apply, `TL_SENSOR_SYNC_EN` undefined.
1. `reset`=1 for 2 cycles, then 0 with raw inputs low → `Ta`=`Tb`=0 and counts 0 throughout.
2. `raw_a` high for 3 cycles, then low → `Ta` never rises; `car_cnt_a`=0.
3. `raw_a` high for 20 cycles, then low → `Ta` rises after the 4th edge, and `car_cnt_a`=1 on that same edge. `Ta` falls after the 8th low edge. `Tb` stays 0.
4. `raw_b` qualified, then low for 5 cycles, then high again → `Tb` stays 1 with no gap; `car_cnt_b` remains 1.
5. 260 qualified pulses on `raw_a` → `car_cnt_a` saturates at 255. Then `clr_cnt` in the same cycle as a qualification → `car_cnt_a`=0.
6. `reset` pulsed while `Ta`=1 and in HOLD → `Ta` drops to 0 without waiting for an edge. With `TL_SENSOR_SYNC_EN` defined, rerun scenario 3 → `Ta` rises after 6 edges.
